register_file_sb: RTL and testbench

- Parametrised multi-port register file for the single-cycle and next pipelined datapath.
- Successor to the fixed 32x32, 2-read/1-write register file.
- Adds configurable width, depth and read-port count, a second write port with collision handling, and optional write-to-read bypass.
- Adds an integrated scoreboard of per-register busy bits with a live busy count, so issue logic can detect RAW hazards.

---
 rtl/rf_pkg.sv | 22 ++
 rtl/register_file_sb_if.sv | 39 +++
 rtl/rf_scoreboard.sv | 81 ++++++++
 rtl/register_file_sb.sv | 92 +++++++++
 tb/tb_register_file_sb.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register_file_sb slice.
//   - Default geometry (data width, register count, read-port count).
//   - ZERO_IDX: index of the hardwired zero register.
//   - clog2: constant-evaluable ceiling log2, used to derive address widths.
package rf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 2;
  localparam int ZERO_IDX   = 0;

  // Smallest r with 2**r >= v; bounded loop so it stays constant-foldable.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/register_file_sb_if.sv
// Bus bundle for register_file_sb.
//   Read side : rdAddr (packed per port), rdData, rdBusy  -- combinational.
//   Write side: wrEnA/wrAddrA/wrDataA, wrEnB/wrAddrB/wrDataB (B wins on same address).
//   Issue side: rsvEn/rsvAddr marks a register busy.
//   Status    : busyCount, wrConflict -- registered.
// Timing contract: there is no valid/ready handshake. Every enable is a
// single-cycle qualifier sampled at the rising edge of clk; nothing stalls.
interface register_file_sb_if #(
  parameter int DATA_W = rf_pkg::DEF_DATA_W,
  parameter int DEPTH  = rf_pkg::DEF_DEPTH,
  parameter int NUM_RD = rf_pkg::DEF_NUM_RD
);
  localparam int ADDR_W = rf_pkg::clog2(DEPTH);

  logic [NUM_RD*ADDR_W-1:0] rdAddr;
  logic [NUM_RD*DATA_W-1:0] rdData;
  logic [NUM_RD-1:0]        rdBusy;
  logic                     wrEnA;
  logic [ADDR_W-1:0]        wrAddrA;
  logic [DATA_W-1:0]        wrDataA;
  logic                     wrEnB;
  logic [ADDR_W-1:0]        wrAddrB;
  logic [DATA_W-1:0]        wrDataB;
  logic                     rsvEn;
  logic [ADDR_W-1:0]        rsvAddr;
  logic [ADDR_W:0]          busyCount;
  logic                     wrConflict;

  modport master (
    output rdAddr, wrEnA, wrAddrA, wrDataA, wrEnB, wrAddrB, wrDataB, rsvEn, rsvAddr,
    input  rdData, rdBusy, busyCount, wrConflict
  );

  modport slave (
    input  rdAddr, wrEnA, wrAddrA, wrDataA, wrEnB, wrAddrB, wrDataB, rsvEn, rsvAddr,
    output rdData, rdBusy, busyCount, wrConflict
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for RAW hazard detection.
//   clk, rst               : clock, synchronous active-high reset
//   wr_en_*/wr_addr_*      : write ports A and B (a write clears busy)
//   rsv_en/rsv_addr        : reserve (sets busy; wins over a same-cycle write)
//   busy_o                 : current busy vector
//   busy_next_o            : busy vector after the coming edge (for bypassed rdBusy)
//   busy_count_o           : registered popcount of busy_o, kept incrementally
//   wr_conflict_o          : registered pulse after an A/B same-address write
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_a,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DEPTH-1:0]  busy_o,
  output logic [DEPTH-1:0]  busy_next_o,
  output logic [ADDR_W:0]   busy_count_o,
  output logic              wr_conflict_o
);

  localparam int CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             conflict_q, conflict_d;
  logic             a_eff, b_eff, r_eff;
  logic             set_inc, clr_a, clr_b;

  always_comb begin
    // Traffic to the zero register is discarded before it reaches the busy bits.
    a_eff = wr_en_a && !(ZERO_REG != 0 && wr_addr_a == ADDR_W'(ZERO_IDX));
    b_eff = wr_en_b && !(ZERO_REG != 0 && wr_addr_b == ADDR_W'(ZERO_IDX));
    r_eff = rsv_en  && !(ZERO_REG != 0 && rsv_addr  == ADDR_W'(ZERO_IDX));

    // Reserve is applied last so a new producer overrides a retiring one.
    busy_d = busy_q;
    if (a_eff) busy_d[wr_addr_a] = 1'b0;
    if (b_eff) busy_d[wr_addr_b] = 1'b0;
    if (r_eff) busy_d[rsv_addr]  = 1'b1;

    // Incremental count: each term is a real 0->1 or 1->0 transition.
    // A is not counted when B hits the same address, so one bit clears once.
    set_inc = r_eff && !busy_q[rsv_addr];
    clr_a   = a_eff && busy_q[wr_addr_a]
              && !(r_eff && rsv_addr == wr_addr_a)
              && !(b_eff && wr_addr_b == wr_addr_a);
    clr_b   = b_eff && busy_q[wr_addr_b]
              && !(r_eff && rsv_addr == wr_addr_b);
    count_d = count_q + CNT_W'(set_inc) - CNT_W'(clr_a) - CNT_W'(clr_b);

    // Collision is flagged on raw enables, even when address 0 swallows the data.
    conflict_d = wr_en_a && wr_en_b && (wr_addr_a == wr_addr_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      count_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      count_q    <= count_d;
      conflict_q <= conflict_d;
    end
  end

  assign busy_o        = busy_q;
  assign busy_next_o   = busy_d;
  assign busy_count_o  = count_q;
  assign wr_conflict_o = conflict_q;

endmodule

// File: rtl/register_file_sb.sv
// Multi-port register file with integrated busy scoreboard.
//   clk, rst : clock, synchronous active-high reset (clears data and busy bits)
//   bus      : register_file_sb_if slave -- NUM_RD combinational read ports
//              (data + busy), two write ports (B over A), reserve port,
//              registered busyCount and wrConflict.
// BYPASS=1 forwards same-cycle write data and next-state busy to the read ports.
// ZERO_REG=1 pins register 0 to zero and never-busy.
module register_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  register_file_sb_if.slave  bus
);

  localparam int ADDR_W = clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_a_eff, wr_b_eff;
  logic [DEPTH-1:0]  busy_cur, busy_nxt;

  always_comb begin
    wr_a_eff = bus.wrEnA && !(ZERO_REG != 0 && bus.wrAddrA == ADDR_W'(ZERO_IDX));
    wr_b_eff = bus.wrEnB && !(ZERO_REG != 0 && bus.wrAddrB == ADDR_W'(ZERO_IDX));
    // B is applied second so it owns a shared address.
    mem_d = mem_q;
    if (wr_a_eff) mem_d[bus.wrAddrA] = bus.wrDataA;
    if (wr_b_eff) mem_d[bus.wrAddrB] = bus.wrDataB;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .wr_en_a       (bus.wrEnA),
    .wr_addr_a     (bus.wrAddrA),
    .wr_en_b       (bus.wrEnB),
    .wr_addr_b     (bus.wrAddrB),
    .rsv_en        (bus.rsvEn),
    .rsv_addr      (bus.rsvAddr),
    .busy_o        (busy_cur),
    .busy_next_o   (busy_nxt),
    .busy_count_o  (bus.busyCount),
    .wr_conflict_o (bus.wrConflict)
  );

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_busy;
    logic              is_zero;

    assign rd_addr = bus.rdAddr[g*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (rd_addr == ADDR_W'(ZERO_IDX));

    always_comb begin
      rd_data = mem_q[rd_addr];
      rd_busy = busy_cur[rd_addr];
      if (BYPASS != 0) begin
        // Effective enables already exclude address 0 when it is hardwired.
        if (wr_a_eff && bus.wrAddrA == rd_addr) rd_data = bus.wrDataA;
        if (wr_b_eff && bus.wrAddrB == rd_addr) rd_data = bus.wrDataB;
        rd_busy = busy_nxt[rd_addr];
      end
      if (is_zero) begin
        rd_data = '0;
        rd_busy = 1'b0;
      end
    end

    assign bus.rdData[g*DATA_W +: DATA_W] = rd_data;
    assign bus.rdBusy[g]                  = rd_busy;
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: two instances (BYPASS=0 and BYPASS=1) share one
// stimulus stream. A behavioural model (arrays + popcount) predicts every
// output each cycle; directed steps add literal expectations.
module tb_register_file_sb;
  import rf_pkg::*;

  localparam int DW = 32;
  localparam int DP = 32;
  localparam int NR = 2;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus variables ----------------
  logic [NR*AW-1:0] rd_addr = '0;
  logic             wr_en_a = 1'b0, wr_en_b = 1'b0, rsv_en = 1'b0;
  logic [AW-1:0]    wr_addr_a = '0, wr_addr_b = '0, rsv_addr = '0;
  logic [DW-1:0]    wr_data_a = '0, wr_data_b = '0;

  register_file_sb_if #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR)) if0 ();
  register_file_sb_if #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR)) if1 ();

  assign if0.rdAddr = rd_addr;   assign if1.rdAddr = rd_addr;
  assign if0.wrEnA = wr_en_a;    assign if1.wrEnA = wr_en_a;
  assign if0.wrAddrA = wr_addr_a; assign if1.wrAddrA = wr_addr_a;
  assign if0.wrDataA = wr_data_a; assign if1.wrDataA = wr_data_a;
  assign if0.wrEnB = wr_en_b;    assign if1.wrEnB = wr_en_b;
  assign if0.wrAddrB = wr_addr_b; assign if1.wrAddrB = wr_addr_b;
  assign if0.wrDataB = wr_data_b; assign if1.wrDataB = wr_data_b;
  assign if0.rsvEn = rsv_en;     assign if1.rsvEn = rsv_en;
  assign if0.rsvAddr = rsv_addr; assign if1.rsvAddr = rsv_addr;

  register_file_sb #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR), .BYPASS(0), .ZERO_REG(1))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  register_file_sb #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR), .BYPASS(1), .ZERO_REG(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));

  // ---------------- scoreboard bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem  [DP];
  bit            m_busy [DP];
  bit            m_conf;

  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DP; r++) begin
        m_mem[r]  = '0;
        m_busy[r] = 1'b0;
      end
      m_conf = 1'b0;
    end else begin
      m_conf = wr_en_a && wr_en_b && (wr_addr_a == wr_addr_b);
      if (wr_en_a && wr_addr_a != 0) begin m_mem[wr_addr_a] = wr_data_a; m_busy[wr_addr_a] = 1'b0; end
      if (wr_en_b && wr_addr_b != 0) begin m_mem[wr_addr_b] = wr_data_b; m_busy[wr_addr_b] = 1'b0; end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
  end

  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < DP; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  function automatic logic [DW-1:0] exp_data(input bit byp, input int port);
    logic [AW-1:0] a = rd_addr[port*AW +: AW];
    if (a == 0) return '0;
    if (byp && wr_en_b && wr_addr_b == a) return wr_data_b;
    if (byp && wr_en_a && wr_addr_a == a) return wr_data_a;
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input bit byp, input int port);
    logic [AW-1:0] a = rd_addr[port*AW +: AW];
    if (a == 0) return 1'b0;
    if (!byp) return m_busy[a];
    if (rsv_en && rsv_addr == a) return 1'b1;
    if ((wr_en_a && wr_addr_a == a) || (wr_en_b && wr_addr_b == a)) return 1'b0;
    return m_busy[a];
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NR; p++) begin
        check($sformatf("m0_rdData%0d", p), 64'(if0.rdData[p*DW +: DW]), 64'(exp_data(1'b0, p)));
        check($sformatf("m1_rdData%0d", p), 64'(if1.rdData[p*DW +: DW]), 64'(exp_data(1'b1, p)));
        check($sformatf("m0_rdBusy%0d", p), 64'(if0.rdBusy[p]), 64'(exp_busy(1'b0, p)));
        check($sformatf("m1_rdBusy%0d", p), 64'(if1.rdBusy[p]), 64'(exp_busy(1'b1, p)));
      end
      check("m0_busyCount", 64'(if0.busyCount), 64'(m_count()));
      check("m1_busyCount", 64'(if1.busyCount), 64'(m_count()));
      check("m0_wrConflict", 64'(if0.wrConflict), 64'(m_conf));
      check("m1_wrConflict", 64'(if1.wrConflict), 64'(m_conf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle();
    wr_en_a = 1'b0; wr_en_b = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic drive_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en_a = 1'b1; wr_addr_a = a; wr_data_a = d;
  endtask

  task automatic drive_b(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en_b = 1'b1; wr_addr_b = a; wr_data_b = d;
  endtask

  task automatic drive_rsv(input logic [AW-1:0] a);
    rsv_en = 1'b1; rsv_addr = a;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset then read
    rst = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    set_rd(5'd1, 5'd2);
    settle();
    check("rst_rdData", 64'(if0.rdData), 64'd0);
    check("rst_rdBusy", 64'(if0.rdBusy), 64'd0);
    check("rst_busyCount", 64'(if0.busyCount), 64'd0);
    check("rst_wrConflict", 64'(if0.wrConflict), 64'd0);

    // Basic write: non-bypassed sees it after the edge, bypassed at once
    set_rd(5'd6, 5'd1);
    drive_a(5'd6, 32'd12345);
    settle();
    check("wr1_pre_nobyp", 64'(if0.rdData[31:0]), 64'd0);
    check("wr1_pre_byp", 64'(if1.rdData[31:0]), 64'd12345);
    tick(); idle(); settle();
    check("wr1_post_nobyp", 64'(if0.rdData[31:0]), 64'd12345);
    drive_a(5'd6, 32'd67890);
    settle();
    check("wr2_pre_nobyp", 64'(if0.rdData[31:0]), 64'd12345);
    tick(); idle(); settle();
    check("wr2_post_nobyp", 64'(if0.rdData[31:0]), 64'd67890);
    check("wr2_post_byp", 64'(if1.rdData[31:0]), 64'd67890);

    // Zero register: data, busy and count unaffected; conflict still pulses
    set_rd(5'd0, 5'd6);
    drive_a(5'd0, 32'd98765); drive_b(5'd0, 32'd98765); drive_rsv(5'd0);
    settle();
    check("zero_byp_rdData", 64'(if1.rdData[31:0]), 64'd0);
    check("zero_byp_rdBusy", 64'(if1.rdBusy[0]), 64'd0);
    tick(); idle(); settle();
    check("zero_rdData", 64'(if0.rdData[31:0]), 64'd0);
    check("zero_busyCount", 64'(if0.busyCount), 64'd0);
    check("zero_wrConflict", 64'(if0.wrConflict), 64'd1);
    tick(); settle();
    check("zero_wrConflict_end", 64'(if0.wrConflict), 64'd0);

    // Collision with bypass: B wins everywhere
    set_rd(5'd5, 5'd6);
    drive_a(5'd5, 32'd111); drive_b(5'd5, 32'd222);
    settle();
    check("coll_byp_rdData", 64'(if1.rdData[31:0]), 64'd222);
    tick(); idle(); settle();
    check("coll_stored", 64'(if0.rdData[31:0]), 64'd222);
    check("coll_conflict", 64'(if1.wrConflict), 64'd1);
    tick(); settle();
    check("coll_conflict_end", 64'(if1.wrConflict), 64'd0);

    // Scoreboard: reserve 3, 4, 3
    set_rd(5'd3, 5'd4);
    drive_rsv(5'd3); tick(); settle();
    check("sb_count1", 64'(if0.busyCount), 64'd1);
    drive_rsv(5'd4); tick(); settle();
    check("sb_count2", 64'(if0.busyCount), 64'd2);
    drive_rsv(5'd3); tick(); idle(); settle();
    check("sb_count3", 64'(if0.busyCount), 64'd2);
    check("sb_busy3", 64'(if0.rdBusy[0]), 64'd1);
    // Write and reserve the same register: stays busy
    drive_b(5'd3, 32'd7); drive_rsv(5'd3);
    settle();
    check("sb_rsvwr_byp_busy", 64'(if1.rdBusy[0]), 64'd1);
    tick(); idle(); settle();
    check("sb_rsvwr_count", 64'(if0.busyCount), 64'd2);
    check("sb_rsvwr_busy", 64'(if0.rdBusy[0]), 64'd1);
    check("sb_rsvwr_data", 64'(if0.rdData[31:0]), 64'd7);
    // Two clears in one cycle
    drive_a(5'd3, 32'd9); drive_b(5'd4, 32'd10);
    settle();
    check("sb_clr_byp_busy", 64'(if1.rdBusy), 64'd0);
    check("sb_clr_nobyp_busy", 64'(if0.rdBusy), 64'd3);
    tick(); idle(); settle();
    check("sb_clr_count", 64'(if0.busyCount), 64'd0);

    // Reset mid-operation
    drive_rsv(5'd7); tick();
    drive_rsv(5'd8); tick();
    drive_rsv(5'd9); tick(); idle(); settle();
    check("mid_count3", 64'(if0.busyCount), 64'd3);
    drive_a(5'd10, 32'd555);
    rst = 1'b1;
    tick();
    rst = 1'b0; idle();
    set_rd(5'd10, 5'd6);
    settle();
    check("mid_rst_count", 64'(if0.busyCount), 64'd0);
    check("mid_rst_busy", 64'(if1.rdBusy), 64'd0);
    check("mid_rst_data10", 64'(if0.rdData[31:0]), 64'd0);
    check("mid_rst_data6", 64'(if0.rdData[63:32]), 64'd0);

    // Directed mixed traffic, checked cycle by cycle against the model
    for (int k = 0; k < 48; k++) begin
      idle();
      if (k % 2 == 0)  drive_a(AW'((k * 7) % DP), DW'(k * 1000 + 1));
      if (k % 3 == 0)  drive_b(AW'((k * 5) % DP), DW'(k * 77 + 3));
      if (k % 4 != 0)  drive_rsv(AW'((k * 3) % DP));
      set_rd(AW'((k * 7) % DP), AW'((k * 3) % DP));
      tick();
    end
    idle();
    tick();
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
